// File: rtl/odd_parity_serializer.sv
// Parallel-to-serial transmitter: payload bits then one odd-parity bit per frame.
// Define ODD_PARITY_SERIALIZER_MSB_FIRST_EN to shift the payload MSB first (default LSB first).
module odd_parity_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_last
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par;
  logic                  cur_bit;
  logic                  accept;

  // Bit presented on the line and the register image after it has been sent
`ifdef ODD_PARITY_SERIALIZER_MSB_FIRST_EN
  assign cur_bit    = shift_reg[DATA_WIDTH-1];
  assign shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
`else
  assign cur_bit    = shift_reg[0];
  assign shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and line outputs; ready also gated by reset so it drops immediately
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        accept   = in_valid & rst;
        if (accept) state_next = DATA;
      end
      DATA: begin
        ser_out   = cur_bit;
        ser_valid = 1'b1;
        if (bit_cnt == LAST_BIT) state_next = PARITY;
      end
      PARITY: begin
        in_ready   = rst;
        accept     = in_valid & rst;
        ser_out    = par;
        ser_valid  = 1'b1;
        ser_last   = 1'b1;
        state_next = accept ? DATA : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload shifter, bit counter and running parity (seeded with 1 for odd parity)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par       <= 1'b1;
    end else if (accept) begin
      shift_reg <= in_data;
      bit_cnt   <= '0;
      par       <= 1'b1;
    end else if (state == DATA) begin
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt + CNT_W'(1);
      par       <= par ^ cur_bit;
    end
  end

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Scoreboard bench: stimulus queues expected serial bits, a monitor pops and compares.
module tb_odd_parity_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;

  logic [1:0]   sb[$];
  int           checks = 0;
  int           fails = 0;
  int           ones = 0;

  always #5 clk = ~clk;

  odd_parity_serializer #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame: payload in line order, then the hand-computed parity bit
  task automatic push_frame(input logic [W-1:0] w, input logic p);
    for (int k = 0; k < int'(W); k++) begin
`ifdef ODD_PARITY_SERIALIZER_MSB_FIRST_EN
      sb.push_back({1'b0, w[W-1-k]});
`else
      sb.push_back({1'b0, w[k]});
`endif
    end
    sb.push_back({1'b1, p});
  endtask

  task automatic send(input logic [W-1:0] w, input logic p);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: word %h not accepted in %0d cycles", w, t);
    end else begin
      push_frame(w, p);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || ser_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || ser_valid) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d bits still pending", sb.size());
    end
  endtask

  // Monitor: compare every presented bit; also act as a frame-reset odd parity checker
  always @(negedge clk) begin
    logic [1:0] exp;
    if (ser_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_bit: ser_out=%b ser_last=%b with nothing pending", ser_out, ser_last);
      end else begin
        exp = sb.pop_front();
        check("ser_out", ser_out, exp[0]);
        check("ser_last", ser_last, exp[1]);
      end
      ones += int'(ser_out);
      if (ser_last) begin
        check("frame_odd", 1'(ones % 2), 1'b1);
        ones = 0;
      end
    end
  end

  initial begin
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_valid", ser_valid, 1'b0);
    check("rst_out", ser_out, 1'b0);
    check("rst_last", ser_last, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_ready", in_ready, 1'b1);

    // Basic frames: A5 -> parity 1, 07 -> 0, 00 -> 1
    send(8'hA5, 1'b1);
    send(8'h07, 1'b0);
    send(8'h00, 1'b1);
    wait_drain();

    // Back-to-back: second accept lands in the parity cycle of the first frame
    send(8'hFF, 1'b1);
    in_data  = 8'h01;
    in_valid = 1'b1;
    begin
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("b2b_accept_in_parity", ser_last, 1'b1);
    check("b2b_ready", in_ready, 1'b1);
    push_frame(8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_no_gap", ser_valid, 1'b1);
    check("b2b_first_bit_not_last", ser_last, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // in_data changing during DATA must be ignored
    send(8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC3 ^ 8'(i);
      check("busy_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-frame at bit 3 of 3C; the partial frame is dropped
    send(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", ser_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    check("midrst_last", ser_last, 1'b0);
    sb.delete();
    ones = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_release_ready", in_ready, 1'b1);
    check("midrst_release_idle", ser_valid, 1'b0);
    send(8'h81, 1'b1);
    send(8'h80, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    check("final_idle_valid", ser_valid, 1'b0);
    check("final_idle_ready", in_ready, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
